// File: rtl/skein_ubi_sequencer.sv
// Skein UBI front end: collects length and message words, builds padded
// NW x 64-bit blocks with tweaks, then issues the output-stage block.
module skein_ubi_sequencer #(
    parameter int         NW    = 4,
    parameter logic [5:0] T_MSG = 6'd48,
    parameter logic [5:0] T_OUT = 6'd63
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    input  logic            len_ld,
    input  logic [15:0]     idata,
    input  logic            start,
    input  logic            msg_valid,
    input  logic [15:0]     msg_data,
    output logic            msg_ready,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic [64*NW-1:0] blk_data,
    output logic [127:0]    tweak,
    output logic            busy,
    output logic            done
);

    localparam int BB = 8 * NW;
    localparam int M  = 4 * NW;
    localparam int DW = 64 * NW;
    localparam int BW = $clog2(BB + 1);
    localparam int CW = $clog2(M + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, OUT, DONE} state_t;

    state_t state, state_nx;

    logic [63:0]   len;
    logic [63:0]   rem;
    logic [63:0]   pos;
    logic [2:0]    lbits;
    logic          partial;
    logic          first;
    logic [DW-1:0] blk_buf;
    logic [CW-1:0] wcnt;

    logic [BW-1:0] nb;
    logic [BW-1:0] nw;
    logic [BW-1:0] idx;
    logic          take;
    logic          acc;
    logic          load_done;
    logic          last_blk;
    logic          final_blk;
    logic [15:0]   word;
    logic [7:0]    last_byte;
    logic [7:0]    mask;
    logic [7:0]    pad_byte;

    // Bytes and 16-bit words carried by the block currently being loaded
    assign nb        = (rem >= 64'(BB)) ? BW'(BB) : rem[BW-1:0];
    assign nw        = (nb + BW'(1)) >> 1;
    assign idx       = (nb == '0) ? '0 : nb - BW'(1);
    assign msg_ready = (state == LOAD) && (BW'(wcnt) < nw);
    assign load_done = (state == LOAD) && (BW'(wcnt) == nw);
    assign take      = msg_valid && msg_ready;
    assign acc       = blk_valid && blk_ready;
    assign last_blk  = (rem == 64'(nb));
    assign final_blk = (rem == 64'd0);

    always_comb begin
        word = msg_data;
        if (nb[0] && (BW'(wcnt) + BW'(1) == nw))
            word[15:8] = 8'h00;
    end

    assign last_byte = blk_buf[8*idx +: 8];
    assign mask      = 8'h80 >> lbits;
    assign pad_byte  = (last_byte & ~(mask - 8'h01)) | mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (init) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) state_nx = LOAD;
                LOAD:  if (load_done) state_nx = ISSUE;
                ISSUE: if (acc) state_nx = final_blk ? OUT : LOAD;
                OUT:   if (acc) state_nx = DONE;
                DONE:  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len     <= '0;
            rem     <= '0;
            pos     <= '0;
            lbits   <= '0;
            partial <= 1'b0;
            first   <= 1'b0;
            blk_buf <= '0;
            wcnt    <= '0;
        end else if (init) begin
            len     <= '0;
            rem     <= '0;
            pos     <= '0;
            lbits   <= '0;
            partial <= 1'b0;
            first   <= 1'b0;
            blk_buf <= '0;
            wcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (len_ld)
                        len <= {len[47:0], idata};
                    if (start) begin
                        rem     <= {3'b000, len[63:3]} + 64'(|len[2:0]);
                        partial <= |len[2:0];
                        lbits   <= len[2:0];
                        pos     <= '0;
                        first   <= 1'b1;
                        blk_buf <= '0;
                        wcnt    <= '0;
                    end
                end
                LOAD: begin
                    if (take) begin
                        blk_buf[16*wcnt +: 16] <= word;
                        wcnt <= wcnt + CW'(1);
                    end else if (load_done) begin
                        pos <= pos + 64'(nb);
                        rem <= rem - 64'(nb);
                        // Bit-pad the last byte of a partial-byte message
                        if (partial && last_blk && nb != '0)
                            blk_buf[8*idx +: 8] <= pad_byte;
                    end
                end
                ISSUE: begin
                    if (acc) begin
                        first <= 1'b0;
                        if (!final_blk) begin
                            blk_buf <= '0;
                            wcnt    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        blk_valid = 1'b0;
        blk_data  = '0;
        tweak     = '0;
        case (state)
            ISSUE: begin
                blk_valid = 1'b1;
                blk_data  = blk_buf;
                tweak     = {final_blk, first, T_MSG,
                             final_blk & partial, 55'd0, pos};
            end
            OUT: begin
                blk_valid = 1'b1;
                tweak     = {1'b1, 1'b1, T_OUT, 1'b0, 55'd0, 64'd8};
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/skein_ubi_sequencer.md
Name: skein_ubi_sequencer

Overview:
- Parametrised UBI front end for the Skein cores.
- Collects a message bit-length and a 16-bit message word stream, then assembles NW×64-bit blocks.
- Applies byte truncation and bit-padding, and generates the 128-bit tweak (position, type, first, final, bit-pad) for each block.
- Hands each block to a Threefish/UBI core through a valid/ready handshake, followed by the output-stage block. Serves both 256-bit (NW=4) and 512-bit (NW=8) cores.

Parameters:
- NW, 4, 64-bit words per block (4 or 8); block bytes BB = 8·NW; input words per block M = 4·NW.
- T_MSG, 6'd48, UBI type field for message blocks.
- T_OUT, 6'd63, UBI type field for the output block.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- init  in  1  synchronous abort/clear; returns to IDLE and clears the length register and counters.
- len_ld  in  1  shift idata into the 64-bit bit-length register: L <= {L[47:0], idata}.
- idata  in  16  length data, MSB word first.
- start  in  1  begin sequencing with the current L; accepted in IDLE only.
- msg_valid  in  1  message word valid.
- msg_data  in  16  message word; byte k of the message sits at [7:0], byte k+1 at [15:8].
- msg_ready  out  1  word accepted when msg_valid & msg_ready.
- blk_valid  out  1  block and tweak presented to the core.
- blk_ready  in  1  core accepts the block when blk_valid & blk_ready.
- blk_data  out  64·NW  block, little-endian; word j = bits [64j+63:64j].
- tweak  out  128  {T1,T0}; T0 = byte position; T1[63] final, [62] first, [61:56] type, [55] bit-pad, all other T1 bits 0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the output block is accepted.

Behaviour:
- Reset: msg_ready=0, blk_valid=0, blk_data=0, tweak=0, busy=0, done=0, L=0, state=IDLE.
- Derived values, latched at start: B = L[63:3] + (L[2:0]≠0) (total bytes); partial = (L[2:0]≠0); rem = B.
- FSM states: IDLE, LOAD, ISSUE, OUT, DONE.
- IDLE: start → LOAD; first=1; pos=0. len_ld in IDLE only; len_ld is ignored in other states.
- LOAD:
  - Word count for this block: W = min(M, ceil(min(rem,BB)/2)).
  - msg_ready=1 until W words have been taken.
  - Word i fills bits [16i+15:16i]. Unfilled bytes are 0.
  - If the block carries an odd byte count, the last word's [15:8] is forced to 0.
  - When W words are in (immediately if W=0, i.e. L=0), compute pos += min(rem,BB) and rem −= that amount, then go to ISSUE.
- Padding: on the final message block with partial=1, with mask = 1<<(7−L[2:0]), the last byte becomes (byte & ~(mask−1)) | mask.
- ISSUE:
  - blk_valid=1; blk_data and tweak are held stable until the handshake.
  - Tweak: T0=pos; type=T_MSG; first as tracked; final=(rem==0); bit-pad=final&partial.
  - On accept: first<=0. If final → OUT, else clear the buffer → LOAD.
- OUT: blk_valid=1, blk_data=0, T0=8, T1=0xFF00_0000_0000_0000 (type T_OUT, first, final). On accept → DONE.
- DONE: done=1 for one cycle → IDLE. L is retained, so a repeated start re-hashes the same length.
- No combinational path from msg_valid to msg_ready. blk_valid does not depend on blk_ready.
- Same-cycle events:
  - init has priority over everything else, including a handshake in the same cycle.
  - start while busy is ignored.
  - rst_n low mid-block clears all state asynchronously.
- Position arithmetic is 64-bit and does not saturate. Message length is limited to 2^61 bytes by L.
- A block boundary exactly at a message end (B a multiple of BB) sets final on that block; no empty extra block is issued.

Test Plan:
- NW=4, L=0, start → no msg_ready. One block: data 0, T0=0, T1=0xF000_0000_0000_0000. Then the output block T0=8, T1=0xFF00…; done pulses.
- NW=4, L=8, one word 0x00AB → blk_data[7:0]=0xAB, rest 0; T0=1, T1=0xF000….
- NW=4, L=3, word 0x00E5 → byte 0 = 0xF0; T0=1, T1=0xF080_0000_0000_0000.
- NW=4, L=264 (33 B), 17 words:
  - Block 1: T0=32, T1=0x7000…
  - Block 2: T0=33, T1=0xB000…, data byte 0 = byte 32, rest 0.
  - Then the output block.
- Hold blk_ready=0 for 5 cycles in ISSUE → blk_data and tweak stable, msg_ready=0. Assert init mid-LOAD → busy=0 next cycle, no done.
- NW=8, L=512 (64 B), 32 words → a single block, T0=64, T1=0xF000…; done after the output block.
